// File: rtl/snow64_vector_cast_dispatcher_pkg.sv
// ----------------------------------------------------------------------------
// snow64_vector_cast_dispatcher_pkg
//
// Shared types for the vector cast dispatcher and the two casters it drives:
//   - LAR data type and integer lane-size encodings
//   - dispatcher FSM state and cast-kind enums
//   - port bundles for the integer caster and the to/from-bf16 caster
//   - request/response bundles of the dispatcher itself
//   - classify(): maps the two bf16 flags onto a cast kind
// ----------------------------------------------------------------------------
package snow64_vector_cast_dispatcher_pkg;

    localparam int LAR_DATA_WIDTH = 256;

    // Integer lane size encoding used by both casters.
    localparam logic [1:0] INT_SIZE_8  = 2'd0;
    localparam logic [1:0] INT_SIZE_16 = 2'd1;
    localparam logic [1:0] INT_SIZE_32 = 2'd2;
    localparam logic [1:0] INT_SIZE_64 = 2'd3;

    typedef logic [LAR_DATA_WIDTH-1:0] lar_data_t;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_BF16 = 1'b1
    } state_vector_cast_dispatcher_t;

    typedef enum logic [1:0] {
        CAST_INT_TO_INT   = 2'd0,
        CAST_INT_TO_BF16  = 2'd1,
        CAST_BF16_TO_INT  = 2'd2,
        CAST_BF16_TO_BF16 = 2'd3
    } cast_kind_t;

    // Integer vector caster (purely combinational).
    typedef struct packed {
        lar_data_t  to_cast;
        logic       src_type_signedness;
        logic       dst_type_signedness;
        logic [1:0] src_int_type_size;
        logic [1:0] dst_int_type_size;
    } port_in_int_vector_caster_t;

    typedef struct packed {
        lar_data_t data;
    } port_out_int_vector_caster_t;

    // To/from-bf16 vector caster (multi-cycle, start/valid).
    typedef struct packed {
        logic       start;
        lar_data_t  to_cast;
        logic       from_int_or_to_int;   // 1: int -> bf16, 0: bf16 -> int
        logic       type_signedness;
        logic [1:0] int_type_size;
    } port_in_to_or_from_bfloat16_vector_caster_t;

    typedef struct packed {
        logic      valid;
        lar_data_t data;
    } port_out_to_or_from_bfloat16_vector_caster_t;

    // Dispatcher request / response bundles.
    typedef struct packed {
        logic       start;
        lar_data_t  to_cast;
        logic       src_is_bfloat16;
        logic       dst_is_bfloat16;
        logic       src_type_signedness;
        logic       dst_type_signedness;
        logic [1:0] src_int_type_size;
        logic [1:0] dst_int_type_size;
    } port_in_vector_cast_dispatcher_t;

    typedef struct packed {
        logic      busy;
        logic      valid;
        lar_data_t data;
        logic      timeout;
    } port_out_vector_cast_dispatcher_t;

    function automatic cast_kind_t classify(input logic src_is_bf16,
                                            input logic dst_is_bf16);
        cast_kind_t kind;
        case ({src_is_bf16, dst_is_bf16})
            2'b00:   kind = CAST_INT_TO_INT;
            2'b01:   kind = CAST_INT_TO_BF16;
            2'b10:   kind = CAST_BF16_TO_INT;
            default: kind = CAST_BF16_TO_BF16;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/snow64_vector_cast_dispatcher.sv
// ----------------------------------------------------------------------------
// snow64_vector_cast_dispatcher
//
// Front end for the integer and to/from-bf16 vector casters. One cast request
// is accepted in IDLE, classified, and steered:
//   int -> int   : int caster driven combinationally, result registered
//                  at the end of the request cycle
//   bf16 -> bf16 : pass-through, registered at the end of the request cycle
//   int <-> bf16 : request latched into the bf16 caster, start pulsed for one
//                  cycle, wait in WAIT_BF16 for its valid
// Results leave as a registered one-cycle out_valid pulse with out_data held
// until the next result.
//
// Handshake: in_start is a request strobe sampled only in IDLE (no ready; a
// strobe seen in WAIT_BF16 is dropped). out_bf16_caster.start is a one-cycle
// pulse; the first in_bf16_caster.valid seen while waiting, including in the
// start cycle itself, completes the request. out_valid is a one-cycle pulse.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_start, in_to_cast,
//   in_src/dst_*               cast request
//   out_int_caster/in_int_caster    integer caster bundle
//   out_bf16_caster/in_bf16_caster  bf16 caster bundle
//   out_busy                   high while waiting on the bf16 caster
//   out_valid, out_data        result pulse / held result
//   out_timeout                watchdog abort pulse
//
// Optional feature macro: SNOW64_VECTOR_CAST_DISPATCHER_TIMEOUT_EN
//   Adds a wait watchdog of TIMEOUT_CYCLES cycles. Without it the block waits
//   indefinitely and out_timeout is tied low.
// ----------------------------------------------------------------------------
module snow64_vector_cast_dispatcher
    import snow64_vector_cast_dispatcher_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_start,
    input  logic [255:0]                                in_to_cast,
    input  logic                                        in_src_is_bfloat16,
    input  logic                                        in_dst_is_bfloat16,
    input  logic                                        in_src_type_signedness,
    input  logic                                        in_dst_type_signedness,
    input  logic [1:0]                                  in_src_int_type_size,
    input  logic [1:0]                                  in_dst_int_type_size,
    output port_in_int_vector_caster_t                  out_int_caster,
    input  port_out_int_vector_caster_t                 in_int_caster,
    output port_in_to_or_from_bfloat16_vector_caster_t  out_bf16_caster,
    input  port_out_to_or_from_bfloat16_vector_caster_t in_bf16_caster,
    output logic                                        out_busy,
    output logic                                        out_valid,
    output logic [255:0]                                out_data,
    output logic                                        out_timeout
);

    state_vector_cast_dispatcher_t   state;
    port_in_vector_cast_dispatcher_t req;
    cast_kind_t                      kind;
    port_in_int_vector_caster_t      int_req;
    port_in_int_vector_caster_t      int_held;
    logic                            accept;

    assign req = '{
        start:               in_start,
        to_cast:             in_to_cast,
        src_is_bfloat16:     in_src_is_bfloat16,
        dst_is_bfloat16:     in_dst_is_bfloat16,
        src_type_signedness: in_src_type_signedness,
        dst_type_signedness: in_dst_type_signedness,
        src_int_type_size:   in_src_int_type_size,
        dst_int_type_size:   in_dst_int_type_size
    };

    assign kind   = classify(req.src_is_bfloat16, req.dst_is_bfloat16);
    assign accept = req.start && (state == ST_IDLE);

    assign int_req = '{
        to_cast:             req.to_cast,
        src_type_signedness: req.src_type_signedness,
        dst_type_signedness: req.dst_type_signedness,
        src_int_type_size:   req.src_int_type_size,
        dst_int_type_size:   req.dst_int_type_size
    };

    // The int caster sees the live request only during an accepted int->int
    // cycle; otherwise it keeps the last request it was given. Gating with
    // rst keeps the bundle at zero while reset is held.
    always_comb begin
        out_int_caster = int_held;
        if (!rst && accept && (kind == CAST_INT_TO_INT)) begin
            out_int_caster = int_req;
        end
    end

    assign out_busy = (state == ST_WAIT_BF16);

`ifdef SNOW64_VECTOR_CAST_DISPATCHER_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_count;
    logic       timeout_q;
    assign out_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign out_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_bf16_caster <= '0;
            int_held        <= '0;
`ifdef SNOW64_VECTOR_CAST_DISPATCHER_TIMEOUT_EN
            wait_count      <= '0;
            timeout_q       <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef SNOW64_VECTOR_CAST_DISPATCHER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (req.start) begin
                        case (kind)
                            CAST_INT_TO_INT: begin
                                int_held  <= int_req;
                                out_data  <= in_int_caster.data;
                                out_valid <= 1'b1;
                            end
                            CAST_BF16_TO_BF16: begin
                                out_data  <= req.to_cast;
                                out_valid <= 1'b1;
                            end
                            CAST_INT_TO_BF16: begin
                                out_bf16_caster <= '{
                                    start:              1'b1,
                                    to_cast:            req.to_cast,
                                    from_int_or_to_int: 1'b1,
                                    type_signedness:    req.src_type_signedness,
                                    int_type_size:      req.src_int_type_size
                                };
                                state <= ST_WAIT_BF16;
`ifdef SNOW64_VECTOR_CAST_DISPATCHER_TIMEOUT_EN
                                wait_count <= '0;
`endif
                            end
                            default: begin // CAST_BF16_TO_INT
                                out_bf16_caster <= '{
                                    start:              1'b1,
                                    to_cast:            req.to_cast,
                                    from_int_or_to_int: 1'b0,
                                    type_signedness:    req.dst_type_signedness,
                                    int_type_size:      req.dst_int_type_size
                                };
                                state <= ST_WAIT_BF16;
`ifdef SNOW64_VECTOR_CAST_DISPATCHER_TIMEOUT_EN
                                wait_count <= '0;
`endif
                            end
                        endcase
                    end
                end

                default: begin // ST_WAIT_BF16
                    // Data fields stay put; only the start pulse is retired.
                    out_bf16_caster.start <= 1'b0;
                    if (in_bf16_caster.valid) begin
                        out_data  <= in_bf16_caster.data;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
`ifdef SNOW64_VECTOR_CAST_DISPATCHER_TIMEOUT_EN
                    // Valid on the limit cycle wins because it is tested first.
                    else if (wait_count == WAIT_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: doc/snow64_vector_cast_dispatcher.md
Name: snow64_vector_cast_dispatcher

Overview:
- Sequencing front end that sits directly upstream of the integer vector caster and the to/from-BFloat16 vector caster.
- Accepts one LAR-wide cast request, classifies it (int→int, int→bf16, bf16→int, bf16→bf16), and drives the matching caster.
- Waits for the result, then returns it as a registered one-cycle valid pulse to the LAR-file writeback path.

Parameters:
TIMEOUT_CYCLES, 64, bf16 caster wait limit (used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_start  in  1  request strobe; honoured only in IDLE
in_to_cast  in  256  source LarData
in_src_is_bfloat16  in  1  source lanes are bf16
in_dst_is_bfloat16  in  1  destination lanes are bf16
in_src_type_signedness  in  1  source int signedness
in_dst_type_signedness  in  1  destination int signedness
in_src_int_type_size  in  2  source int size (0=8,1=16,2=32,3=64)
in_dst_int_type_size  in  2  destination int size
out_int_caster  out  PortIn_IntVectorCaster  to int caster (combinational)
in_int_caster  in  PortOut_IntVectorCaster  from int caster
out_bf16_caster  out  PortIn_ToOrFromBFloat16VectorCaster  to bf16 caster
in_bf16_caster  in  PortOut_ToOrFromBFloat16VectorCaster  from bf16 caster
out_busy  out  1  state != IDLE
out_valid  out  1  one-cycle result pulse
out_data  out  256  result; held until next out_valid
out_timeout  out  1  one-cycle pulse on watchdog abort (feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - out_valid=0, out_data=0, out_busy=0, out_timeout=0.
  - out_bf16_caster fields all 0; out_int_caster fields all 0.
- States: IDLE, WAIT_BF16.
- IDLE with in_start=1, classified on the inputs of that same cycle N:
  - int→int:
    - out_int_caster is driven from the in_* inputs combinationally.
    - At the edge ending cycle N, out_data ← in_int_caster.data.
    - out_valid=1 in cycle N+1; state stays IDLE.
  - bf16→bf16: out_data ← in_to_cast; out_valid=1 in cycle N+1; stays IDLE.
  - int→bf16:
    - Latch into out_bf16_caster: to_cast=in_to_cast, from_int_or_to_int=1, type_signedness=src, int_type_size=src.
    - start=1 for exactly cycle N+1; go to WAIT_BF16.
  - bf16→int: same as int→bf16 except from_int_or_to_int=0, type_signedness=dst, int_type_size=dst.
- WAIT_BF16:
  - out_bf16_caster data fields are held stable and start=0 after the first cycle.
  - On the first in_bf16_caster.valid=1 at cycle M: out_data ← in_bf16_caster.data, out_valid=1 in cycle M+1, state → IDLE.
  - in_bf16_caster.valid in the same cycle that start is pulsed counts as completion.
- in_start in WAIT_BF16 is dropped silently. No queueing.
- in_bf16_caster.valid while IDLE is ignored.
- Back-to-back: a start is accepted in the same cycle out_valid is high, because state is IDLE.
- out_int_caster holds its last value when not in use. The int caster is purely combinational.
- Reset mid-WAIT_BF16 aborts the request. No out_valid is produced for it, and a late caster valid after reset is ignored.

Optional Feature:
- Macro: SNOW64_VECTOR_CAST_DISPATCHER_TIMEOUT_EN.
- Enabled:
  - An 8-bit cycle counter clears on entering WAIT_BF16 and increments each cycle spent there.
  - If it reaches TIMEOUT_CYCLES without valid: out_timeout=1 for one cycle, state → IDLE, no out_valid, out_data unchanged.
  - If valid arrives on the same cycle as the limit, valid wins.
- Disabled: no counter; WAIT_BF16 waits indefinitely; out_timeout tied 0.

Decomposition:
- PkgSnow64VectorCaster gains:
  - StateVectorCastDispatcher enum (IDLE, WAIT_BF16).
  - Cast-kind enum (IntToInt, IntToBf16, Bf16ToInt, Bf16ToBf16).
  - PortIn_VectorCastDispatcher / PortOut_VectorCastDispatcher structs.
  - Int-size encoding localparams.
- No sub-module. The two casters are instantiated by the parent, not inside this block.

Test Plan:
- int→int: in_to_cast lanes all 0x80, src s8 → dst s16, start at N → out_valid only in N+1; every 16-bit lane 0xFF80; out_busy never 1.
- bf16→bf16: in_to_cast = 16 lanes of 0x3F80, start at N → out_valid at N+1, out_data identical to input.
- int→bf16 with stub caster returning valid 5 cycles after start (data 0x4000 lanes):
  - start at N; out_bf16_caster.start high only in N+1 with from_int_or_to_int=1.
  - out_valid at N+7, data 0x4000 lanes.
- bf16→int: dst u32, stub valid same cycle as start → out_valid at N+2; caster saw type_signedness=0, int_type_size=2.
- in_start pulsed every cycle during a bf16 wait → exactly one out_valid for the first request; start accepted again on the out_valid cycle.
- rst asserted 2 cycles into WAIT_BF16, stub valid arriving afterwards → outputs zero immediately, no out_valid.
- Feature build only: stub never returns valid → out_timeout pulses after 64 wait cycles, state IDLE.
